// File: rtl/alu_pipe_flags.sv
// Registered execute-stage ALU with valid/ready handshake and an NZCV status register.
// Define MUL_EN to build the iterative shift-add multiplier decoded from MUL_CMD.
module alu_pipe_flags #(
  parameter int unsigned        WIDTH   = 32,
  parameter int unsigned        CMD_LEN = 4,
  parameter logic [CMD_LEN-1:0] MUL_CMD = 4'b1010
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CMD_LEN-1:0] cmd,
  input  logic               s_bit,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic [3:0]         status
);

  typedef enum logic [CMD_LEN-1:0] {
    CMD_MOV = CMD_LEN'(0),
    CMD_MVN = CMD_LEN'(1),
    CMD_ADD = CMD_LEN'(2),
    CMD_ADC = CMD_LEN'(3),
    CMD_SUB = CMD_LEN'(4),
    CMD_SBC = CMD_LEN'(5),
    CMD_AND = CMD_LEN'(6),
    CMD_ORR = CMD_LEN'(7),
    CMD_EOR = CMD_LEN'(8),
    CMD_CMP = CMD_LEN'(9),
    CMD_TST = CMD_LEN'(11),
    CMD_LDR = CMD_LEN'(12),
    CMD_STR = CMD_LEN'(13)
  } cmd_e;

  logic             accept;
  logic             take_single;
  logic             is_mul;
  logic             idle;
  logic             known;
  logic             arith;
  logic             sub;
  logic             use_carry;
  logic             flag_force;
  logic             flag_wr;
  logic [WIDTH-1:0] logic_res;
  logic [WIDTH-1:0] b_eff;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             v_new;
  logic [3:0]       next_status;

  // MUL_CMD takes precedence over any other decode; without the multiplier it is an unknown op.
  assign is_mul = (cmd == MUL_CMD);

  always_comb begin
    known      = 1'b1;
    arith      = 1'b0;
    sub        = 1'b0;
    use_carry  = 1'b0;
    flag_force = 1'b0;
    logic_res  = '0;
    case (cmd)
      CMD_MOV: logic_res = op_b;
      CMD_MVN: logic_res = ~op_b;
      CMD_ADD, CMD_LDR, CMD_STR: arith = 1'b1;
      CMD_ADC: begin
        arith     = 1'b1;
        use_carry = 1'b1;
      end
      CMD_SUB: begin
        arith = 1'b1;
        sub   = 1'b1;
      end
      CMD_SBC: begin
        arith     = 1'b1;
        sub       = 1'b1;
        use_carry = 1'b1;
      end
      CMD_CMP: begin
        arith      = 1'b1;
        sub        = 1'b1;
        flag_force = 1'b1;
      end
      CMD_AND: logic_res = op_a & op_b;
      CMD_TST: begin
        logic_res  = op_a & op_b;
        flag_force = 1'b1;
      end
      CMD_ORR: logic_res = op_a | op_b;
      CMD_EOR: logic_res = op_a ^ op_b;
      default: known = 1'b0;
    endcase
    if (is_mul) known = 1'b0;
  end

  // Subtraction is a + ~b + cin, so the carry out is the ARM-style NOT borrow.
  assign b_eff = sub ? ~op_b : op_b;
  assign cin   = use_carry ? status[1] : sub;
  assign sum   = {1'b0, op_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};

  always_comb begin
    alu_res = '0;
    if (known) alu_res = arith ? sum[WIDTH-1:0] : logic_res;
  end

  always_comb begin
    if (sub)
      v_new = (op_a[WIDTH-1] != op_b[WIDTH-1]) & (sum[WIDTH-1] != op_a[WIDTH-1]);
    else
      v_new = (op_a[WIDTH-1] == op_b[WIDTH-1]) & (sum[WIDTH-1] != op_a[WIDTH-1]);
  end

  always_comb begin
    next_status[3] = alu_res[WIDTH-1];
    next_status[2] = (alu_res == '0);
    next_status[1] = arith ? sum[WIDTH] : status[1];
    next_status[0] = arith ? v_new : status[0];
  end

  assign flag_wr  = known & (s_bit | flag_force);
  assign in_ready = idle & (!out_valid | out_ready) & !flush;
  assign accept   = in_valid & in_ready;

`ifdef MUL_EN
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    MUL_BUSY,
    MUL_DONE
  } state_e;

  state_e           state;
  state_e           state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic             mul_s;
  logic             mul_start;
  logic             mul_load;
  logic             mul_last;

  assign idle        = (state == IDLE);
  assign mul_start   = accept & is_mul;
  assign take_single = accept & !is_mul;
  assign mul_last    = (count == CW'(WIDTH - 1));
  assign mul_load    = (state == MUL_DONE) & (!out_valid | out_ready) & !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (mul_start) state_next = MUL_BUSY;
      MUL_BUSY: if (mul_last)  state_next = MUL_DONE;
      MUL_DONE: if (mul_load)  state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      mul_s  <= 1'b0;
    end else if (flush) begin
      count <= '0;
    end else if (mul_start) begin
      count  <= '0;
      mcand  <= op_a;
      mplier <= op_b;
      acc    <= '0;
      mul_s  <= s_bit;
    end else if (state == MUL_BUSY) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= mul_last ? '0 : count + CW'(1);
    end
  end
`else
  assign idle        = 1'b1;
  assign take_single = accept;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      status    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (take_single) begin
      out_valid <= 1'b1;
      result    <= alu_res;
      if (flag_wr) status <= next_status;
`ifdef MUL_EN
    end else if (mul_load) begin
      out_valid <= 1'b1;
      result    <= acc;
      if (mul_s) status <= {acc[WIDTH-1], (acc == '0), status[1:0]};
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
